// File: rtl/riscv_pkg.sv
// Shared core-wide definitions used by the data-memory responder.
package riscv_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int BE_WIDTH    = DATA_WIDTH / 8;
   localparam int DMEM_WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data memory with per-byte write lanes and a registered read.
// Contents are deliberately not reset.
module dmem_array #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_BITS   = 10
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [DATA_WIDTH/8-1:0]   be,
   input  logic [ADDR_BITS-1:0]      waddr,
   input  logic [ADDR_BITS-1:0]      raddr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH-1:0]     rdata
);

   localparam int BW = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   // Byte-lane write and registered full-word read on every rising edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BW; i++) begin
         if (we && be[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then issues a single-cycle response.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready depends on state only. The response is
// a one-cycle rsp_valid pulse; rdata and rsp_err are meaningful only with it.
module data_mem_responder
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH  = riscv_pkg::DATA_WIDTH,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    we,
   input  logic                    re,
   input  logic [DATA_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] be,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rsp_err,
   output dmem_state_t             fsm_state
);

   localparam int BW        = DATA_WIDTH / 8;
   localparam int ADDR_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [DATA_WIDTH:0]       ADDR_LIMIT = (DATA_WIDTH+1)'(4 * DEPTH_WORDS);
   localparam logic [DMEM_WAIT_W-1:0]    WAIT_INIT  = DMEM_WAIT_W'(WAIT_STATES);

   dmem_state_t            state_q, next_state;
   logic [DMEM_WAIT_W-1:0] cnt_q;

   logic                  we_q, re_q;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q;
   logic [BW-1:0]         be_q;
   logic                  err_q, load_q;

   logic                  cur_we, cur_re;
   logic [DATA_WIDTH-1:0] cur_addr, cur_wdata;
   logic [BW-1:0]         cur_be;
   logic                  cur_err;
   logic                  enter_resp;
   logic                  arr_we;
   logic [DATA_WIDTH-1:0] arr_rdata;

   // Request seen by the array: live inputs in IDLE (zero-wait accept goes
   // straight to RESP), otherwise the latched copy.
   always_comb begin
      cur_we    = we_q;
      cur_re    = re_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
      if (state_q == IDLE) begin
         cur_we    = we;
         cur_re    = re;
         cur_addr  = addr;
         cur_wdata = wdata;
         cur_be    = be;
      end
   end

   // Reject conflicting, misaligned, out-of-range and empty-lane requests.
   always_comb begin
      cur_err = 1'b0;
      if (cur_we && cur_re)                        cur_err = 1'b1;
      if (cur_addr[1:0] != 2'b00)                  cur_err = 1'b1;
      if ({1'b0, cur_addr} >= ADDR_LIMIT)          cur_err = 1'b1;
      if (cur_we && (cur_be == '0))                cur_err = 1'b1;
   end

   assign enter_resp = (next_state == RESP);
   assign arr_we     = rst_n && enter_resp && cur_we && !cur_err;

   dmem_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_BITS   (ADDR_BITS)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (cur_be),
      .waddr (cur_addr[ADDR_BITS+1:2]),
      .raddr (cur_addr[ADDR_BITS+1:2]),
      .wdata (cur_wdata),
      .rdata (arr_rdata)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= next_state;
   end

   // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
   always_comb begin
      next_state = state_q;
      case (state_q)
         IDLE: if (req_valid) next_state = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT: if (cnt_q <= 4'd1) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs decoded from state and the response flags captured on RESP entry.
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_err   = rsp_valid && err_q;
      rdata     = (rsp_valid && load_q) ? arr_rdata : '0;
      fsm_state = state_q;
   end

   // Wait counter: loaded on accept, decremented while waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == IDLE && req_valid) begin
         cnt_q <= WAIT_INIT;
      end else if (state_q == WAIT) begin
         cnt_q <= cnt_q - 4'd1;
      end else if (state_q == RESP) begin
         cnt_q <= '0;
      end
   end

   // Request latch, captured on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (state_q == IDLE && req_valid) begin
         we_q    <= we;
         re_q    <= re;
         addr_q  <= addr;
         wdata_q <= wdata;
         be_q    <= be;
      end
   end

   // Response flags, captured on the same edge the array is accessed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q  <= 1'b0;
         load_q <= 1'b0;
      end else if (enter_resp) begin
         err_q  <= cur_err;
         load_q <= cur_re && !cur_we && !cur_err;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors on a
// two-wait-state instance, plus reset-abort and back-to-back handshake
// sequences on a zero-wait-state instance.
module tb_data_mem_responder;
   import riscv_pkg::*;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // two-wait-state instance
   logic        r_valid = 0, r_we = 0, r_re = 0;
   logic [31:0] r_addr = 0, r_wdata = 0;
   logic [3:0]  r_be = 0;
   logic        ready2, rsp2, err2;
   logic [31:0] rdata2;
   dmem_state_t st2;

   // zero-wait-state instance
   logic        h_valid = 0, h_we = 0, h_re = 0;
   logic [31:0] h_addr = 0, h_wdata = 0;
   logic [3:0]  h_be = 0;
   logic        ready0, rsp0, err0;
   logic [31:0] rdata0;
   dmem_state_t st0;

   int n_pass = 0;
   int n_total = 0;
   logic [31:0] exp_q[$];

   vec_t vecs[15];

   // clock
   always #5 clk = ~clk;

   data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(r_valid), .req_ready(ready2),
      .we(r_we), .re(r_re), .addr(r_addr), .wdata(r_wdata), .be(r_be),
      .rsp_valid(rsp2), .rdata(rdata2), .rsp_err(err2), .fsm_state(st2)
   );

   data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(h_valid), .req_ready(ready0),
      .we(h_we), .re(h_re), .addr(h_addr), .wdata(h_wdata), .be(h_be),
      .rsp_valid(rsp0), .rdata(rdata0), .rsp_err(err0), .fsm_state(st0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Drive one request into the two-wait instance and check its response.
   task automatic do_req(input vec_t v, input string tag);
      int lat;
      bit got;
      logic [31:0] exp_d;
      logic [31:0] cap_d;
      logic cap_e;
      @(negedge clk);
      check({tag, " ready_before"}, 32'(ready2), 32'd1);
      r_we = v.we; r_re = v.re; r_addr = v.addr; r_wdata = v.wdata; r_be = v.be;
      r_valid = 1'b1;
      exp_q.push_back(v.exp_rdata);
      @(posedge clk);
      lat = 0; got = 0; cap_d = '0; cap_e = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         r_valid = 1'b0;
         if (rsp2) begin
            got = 1; cap_d = rdata2; cap_e = err2;
         end else begin
            lat++;
         end
      end
      exp_d = exp_q.pop_front();
      if (!got) begin
         n_total++;
         $display("FAIL %s timeout: no rsp_valid within 20 cycles", tag);
      end else begin
         check({tag, " latency"}, 32'(lat), 32'd2);
         check({tag, " rdata"}, cap_d, exp_d);
         check({tag, " rsp_err"}, 32'(cap_e), 32'(v.exp_err));
         @(negedge clk);
         check({tag, " single_pulse"}, 32'(rsp2), 32'd0);
         check({tag, " ready_after"}, 32'(ready2), 32'd1);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 32'h40,       32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'h40,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h80,       32'h11223344, 4'hF, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h80,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h80,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h42,       32'h0,        4'h0, 32'h0,        1'b1};
      vecs[6]  = '{1'b0, 1'b1, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1};
      vecs[7]  = '{1'b1, 1'b1, 32'h40,       32'h12345678, 4'hF, 32'h0,        1'b1};
      vecs[8]  = '{1'b1, 1'b0, 32'h40,       32'h55555555, 4'h0, 32'h0,        1'b1};
      vecs[9]  = '{1'b1, 1'b0, 32'h1000,     32'h66666666, 4'hF, 32'h0,        1'b1};
      vecs[10] = '{1'b0, 1'b1, 32'h40,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h40,       32'h0,        4'hF, 32'h0,        1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'hFFC,      32'h01020304, 4'hF, 32'h0,        1'b0};
      vecs[13] = '{1'b0, 1'b1, 32'hFFC,      32'h0,        4'h0, 32'h01020304, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

      // reset state
      repeat (2) @(negedge clk);
      check("reset ready", 32'(ready2), 32'd1);
      check("reset rsp_valid", 32'(rsp2), 32'd0);
      check("reset rdata", rdata2, 32'd0);
      check("reset rsp_err", 32'(err2), 32'd0);
      check("reset state", 32'(st2), 32'(IDLE));
      rst_n = 1'b1;

      // vector table
      for (int i = 0; i < 15; i++) begin
         do_req(vecs[i], $sformatf("vec%0d", i));
      end

      // reset while a store is waiting: store must be dropped
      do_req('{1'b1, 1'b0, 32'h10, 32'h01234567, 4'hF, 32'h0, 1'b0}, "pre_store");
      @(negedge clk);
      r_we = 1'b1; r_re = 1'b0; r_addr = 32'h10; r_wdata = 32'hDEADBEEF; r_be = 4'hF;
      r_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      r_valid = 1'b0;
      check("abort in_wait", 32'(st2), 32'(WAIT));
      rst_n = 1'b0;
      #1;
      check("abort ready_in_reset", 32'(ready2), 32'd1);
      check("abort rsp_in_reset", 32'(rsp2), 32'd0);
      check("abort state_in_reset", 32'(st2), 32'(IDLE));
      @(negedge clk);
      check("abort rsp_in_reset2", 32'(rsp2), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("abort no_rsp%0d", k), 32'(rsp2), 32'd0);
      end
      do_req('{1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'h01234567, 1'b0}, "post_abort_load");

      // zero-wait instance: req_valid held high continuously
      @(negedge clk);
      h_we = 1'b0; h_re = 1'b0; h_addr = 32'h0; h_be = 4'h0; h_valid = 1'b1;
      #1;
      check("hs ready_first", 32'(ready0), 32'd1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("hs rsp%0d", k), 32'(rsp0), (k % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("hs ready%0d", k), 32'(ready0), (k % 2 == 0) ? 32'd0 : 32'd1);
         if (rsp0) begin
            check($sformatf("hs err%0d", k), 32'(err0), 32'd0);
            check($sformatf("hs rdata%0d", k), rdata0, 32'd0);
         end
      end
      h_valid = 1'b0;

      // zero-wait store then load: response on the cycle after accept
      @(negedge clk);
      h_we = 1'b1; h_re = 1'b0; h_addr = 32'h20; h_wdata = 32'hA5A55A5A; h_be = 4'hF; h_valid = 1'b1;
      @(negedge clk);
      h_valid = 1'b0;
      check("w0 store rsp", 32'(rsp0), 32'd1);
      check("w0 store err", 32'(err0), 32'd0);
      @(negedge clk);
      h_we = 1'b0; h_re = 1'b1; h_valid = 1'b1;
      @(negedge clk);
      h_valid = 1'b0;
      check("w0 load rsp", 32'(rsp0), 32'd1);
      check("w0 load rdata", rdata0, 32'hA5A55A5A);
      @(negedge clk);
      check("w0 load single_pulse", 32'(rsp0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "timeout");
   end

endmodule
